// File: rtl/mvma_stream_driver_if.sv
// Stream bundle between the driver and the MVMA accelerator: operand path (m_*) and result path (s_*).
interface mvma_stream_driver_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
);
  logic             m_valid;
  logic             m_ready;
  logic [IN_W-1:0]  m_data;
  logic             s_valid;
  logic             s_ready;
  logic [OUT_W-1:0] s_data;
  logic             s_overflow;

  modport master (
    output m_valid, m_data, s_ready,
    input  m_ready, s_valid, s_data, s_overflow
  );

  modport slave (
    input  m_valid, m_data, s_ready,
    output m_ready, s_valid, s_data, s_overflow
  );
endinterface

// File: rtl/mvma_stream_driver.sv
// Streams a host-loaded operand image (A, b, x) into the MVMA accelerator and collects N results + overflow flags.
// First word the cycle after start; done NW+N+1 cycles after start when unstalled; m_ready stalls SEND, sink_hold stalls RECV.
module mvma_stream_driver #(
  parameter  int N     = 3,
  parameter  int IN_W  = 8,
  parameter  int OUT_W = 16,
  localparam int NW    = N*N + 2*N,
  localparam int AW    = $clog2(NW),
  localparam int RW    = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ld_en,
  input  logic [AW-1:0]         ld_addr,
  input  logic [IN_W-1:0]       ld_data,
  input  logic                  start,
  input  logic                  sink_hold,
  input  logic [RW-1:0]         rd_addr,
  output logic [OUT_W-1:0]      rd_data,
  output logic                  rd_ovf,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf_any,
  mvma_stream_driver_if.master  st
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] RECV = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [AW-1:0] LAST_SEND = AW'(NW - 1);
  localparam logic [RW-1:0] LAST_RECV = RW'(N - 1);

  logic [1:0]       state;
  logic [AW-1:0]    send_idx;
  logic [RW-1:0]    recv_idx;
  logic [IN_W-1:0]  opbuf [NW];
  logic [OUT_W-1:0] res   [N];
  logic [N-1:0]     ovfbuf;
  logic             ld_ok;
  logic             rd_hit;
  logic             accept;

  assign ld_ok  = ld_en && ((state == IDLE) || (state == DONE)) && (int'(ld_addr) < NW);
  assign rd_hit = int'(rd_addr) < N;
  assign accept = st.s_valid && st.s_ready;

  // Stream outputs decode straight from state so an async reset drops m_valid immediately.
  assign st.m_valid = (state == SEND);
  assign st.m_data  = opbuf[send_idx];
  assign st.s_ready = (state == RECV) && !sink_hold;
  assign busy       = (state == SEND) || (state == RECV);
  assign done       = (state == DONE);

  // Operand image survives reset so the host need not reload after an abort.
  always_ff @(posedge clk) begin
    if (ld_ok) begin
      opbuf[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      send_idx <= '0;
      recv_idx <= '0;
      ovf_any  <= 1'b0;
      res      <= '{default: '0};
      ovfbuf   <= '0;
      rd_data  <= '0;
      rd_ovf   <= 1'b0;
    end else begin
      rd_data <= rd_hit ? res[rd_addr] : '0;
      rd_ovf  <= rd_hit ? ovfbuf[rd_addr] : 1'b0;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= SEND;
            send_idx <= '0;
            recv_idx <= '0;
            ovf_any  <= 1'b0;
          end
        end
        SEND: begin
          // Index holds at the last word rather than wrapping.
          if (st.m_ready) begin
            if (send_idx == LAST_SEND) begin
              state <= RECV;
            end else begin
              send_idx <= send_idx + AW'(1);
            end
          end
        end
        RECV: begin
          if (accept) begin
            res[recv_idx]    <= st.s_data;
            ovfbuf[recv_idx] <= st.s_overflow;
            ovf_any          <= ovf_any | st.s_overflow;
            if (recv_idx == LAST_RECV) begin
              state <= DONE;
            end else begin
              recv_idx <= recv_idx + RW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
